// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, stage-control bundle
// and the hard-wired zero register index that never creates a dependency.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    FWAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_F;
    logic stall_D;
    logic flush_D;
    logic stall_E;
    logic flush_E;
    logic stall_M;
    logic flush_W;
  } stage_ctrl_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: D/E/M hazard inputs, memory handshakes,
// per-stage stall/flush controls, watchdog flag and perf counters.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rs1_D;
  logic [REG_AW-1:0] rs2_D;
  logic              rs1_used_D;
  logic              rs2_used_D;
  logic [REG_AW-1:0] rd_E;
  logic              mem_read_E;
  logic              redirect_E;
  logic              imem_ready;
  logic              dmem_req_M;
  logic              dmem_ready;

  logic              stall_F;
  logic              stall_D;
  logic              flush_D;
  logic              stall_E;
  logic              flush_E;
  logic              stall_M;
  logic              flush_W;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_E, mem_read_E,
           redirect_E, imem_ready, dmem_req_M, dmem_ready,
    input  stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_E, mem_read_E,
           redirect_E, imem_ready, dmem_req_M, dmem_ready,
    output stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W,
           mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hz_perf_cnt.sv
// Event counter with enable and synchronous clear; one-cycle update latency.
// SAT=1 holds at MAX (watchdog use), SAT=0 wraps modulo 2^W (perf counter use).
module hz_perf_cnt #(
  parameter int W   = 32,
  parameter bit SAT = 1'b0,
  parameter int MAX = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(SAT && (cnt_q == W'(MAX)))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: combinational per-stage stall/flush (zero latency), a
// RUN/DWAIT/FWAIT tracker, a sticky dmem-wait watchdog and stall/flush perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int WAIT_TO = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WD_W = $clog2(WAIT_TO + 1);

  hz_state_t         state_q, state_d;
  stage_ctrl_t       ctrl;
  logic              lu;
  logic              dw;
  logic              fetch_miss;
  logic              timeout_q, timeout_d;
  logic              wd_hit;
  logic [WD_W-1:0]   wd_cnt;

  assign dw = hz.dmem_req_M & ~hz.dmem_ready;
  assign lu = hz.mem_read_E & (hz.rd_E != REG_AW'(REG_ZERO)) &
              ((hz.rs1_used_D & (hz.rs1_D == hz.rd_E)) |
               (hz.rs2_used_D & (hz.rs2_D == hz.rd_E)));
  assign fetch_miss = hz.redirect_E & ~hz.imem_ready;

  // FWAIT outranks load-use: D only holds a bubble while the redirect target is fetched.
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      if (dw) begin
        ctrl.stall_F = 1'b1;
        ctrl.stall_D = 1'b1;
        ctrl.stall_E = 1'b1;
        ctrl.stall_M = 1'b1;
        ctrl.flush_W = 1'b1;
      end else if (hz.redirect_E) begin
        ctrl.flush_D = 1'b1;
        ctrl.flush_E = 1'b1;
      end else if ((state_q == FWAIT) && !hz.imem_ready) begin
        ctrl.stall_F = 1'b1;
        ctrl.flush_D = 1'b1;
      end else if (lu) begin
        ctrl.stall_F = 1'b1;
        ctrl.stall_D = 1'b1;
        ctrl.flush_E = 1'b1;
      end else if (!hz.imem_ready) begin
        ctrl.stall_F = 1'b1;
        ctrl.flush_D = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fetch_miss) state_d = FWAIT;
      DWAIT:   if (hz.dmem_ready) state_d = fetch_miss ? FWAIT : RUN;
      FWAIT:   if (hz.imem_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (dw) begin
      state_d = DWAIT;
    end
  end

  // Flag rises on the edge that takes the wait count to WAIT_TO.
  assign wd_hit    = dw & (wd_cnt >= WD_W'(WAIT_TO - 1));
  assign timeout_d = timeout_q | wd_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  hz_perf_cnt #(.W(WD_W), .SAT(1'b1), .MAX(WAIT_TO)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (dw),
    .clr_i (~dw),
    .cnt_o (wd_cnt)
  );

  hz_perf_cnt #(.W(CNT_W), .SAT(1'b0), .MAX(0)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ctrl.stall_F),
    .clr_i (1'b0),
    .cnt_o (hz.stall_cnt)
  );

  hz_perf_cnt #(.W(CNT_W), .SAT(1'b0), .MAX(0)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ctrl.flush_D | ctrl.flush_E),
    .clr_i (1'b0),
    .cnt_o (hz.flush_cnt)
  );

  assign hz.stall_F     = ctrl.stall_F;
  assign hz.stall_D     = ctrl.stall_D;
  assign hz.flush_D     = ctrl.flush_D;
  assign hz.stall_E     = ctrl.stall_E;
  assign hz.flush_E     = ctrl.flush_E;
  assign hz.stall_M     = ctrl.stall_M;
  assign hz.flush_W     = ctrl.flush_W;
  assign hz.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a rule-level reference model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int WAIT_TO = 16;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .WAIT_TO(WAIT_TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W}
  logic [6:0] dut_ctrl;
  assign dut_ctrl = {hz.stall_F, hz.stall_D, hz.flush_D, hz.stall_E,
                     hz.flush_E, hz.stall_M, hz.flush_W};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state: pending redirect fetch, wait run length, sticky flag, counters.
  bit          m_fwait = 1'b0;
  int          m_wd    = 0;
  bit          m_to    = 1'b0;
  bit [31:0]   m_stall = '0;
  bit [31:0]   m_flush = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_dw();
    return hz.dmem_req_M && !hz.dmem_ready;
  endfunction

  function automatic logic [6:0] exp_ctrl();
    bit lu;
    lu = hz.mem_read_E && (hz.rd_E != 0) &&
         ((hz.rs1_used_D && hz.rs1_D == hz.rd_E) || (hz.rs2_used_D && hz.rs2_D == hz.rd_E));
    if (!rst_n)                       return 7'b0000000;
    if (m_dw())                       return 7'b1101011;
    if (hz.redirect_E)                return 7'b0010100;
    if (m_fwait && !hz.imem_ready)    return 7'b1010000;
    if (lu)                           return 7'b1100100;
    if (!hz.imem_ready)               return 7'b1010000;
    return 7'b0000000;
  endfunction

  always @(posedge clk) begin
    logic [6:0] e;
    e = exp_ctrl();
    if (!rst_n) begin
      m_fwait = 1'b0;
      m_wd    = 0;
      m_to    = 1'b0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (e[6])        m_stall = m_stall + 1;
      if (e[4] | e[2]) m_flush = m_flush + 1;
      if (m_dw())                                  m_fwait = 1'b0;
      else if (hz.redirect_E && !hz.imem_ready)    m_fwait = 1'b1;
      else if (hz.imem_ready)                      m_fwait = 1'b0;
      if (m_dw()) begin
        if (m_wd < WAIT_TO) m_wd = m_wd + 1;
        if (m_wd >= WAIT_TO) m_to = 1'b1;
      end else begin
        m_wd = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ctrl", dut_ctrl, exp_ctrl());
      chk("model_timeout", hz.mem_timeout, m_to);
      chk("model_stall_cnt", hz.stall_cnt, m_stall);
      chk("model_flush_cnt", hz.flush_cnt, m_flush);
    end
  end

  task automatic idle();
    hz.rs1_D      = '0;
    hz.rs2_D      = '0;
    hz.rs1_used_D = 1'b0;
    hz.rs2_used_D = 1'b0;
    hz.rd_E       = '0;
    hz.mem_read_E = 1'b0;
    hz.redirect_E = 1'b0;
    hz.imem_ready = 1'b1;
    hz.dmem_req_M = 1'b0;
    hz.dmem_ready = 1'b0;
  endtask

  task automatic lu_on();
    hz.mem_read_E = 1'b1;
    hz.rd_E       = 5'd5;
    hz.rs1_D      = 5'd5;
    hz.rs1_used_D = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    hz.imem_ready = 1'b0;
    hz.dmem_req_M = 1'b1;
    nxt();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_forces_ctrl_zero", dut_ctrl, 7'b0);
    nxt();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("reset_stall_cnt", hz.stall_cnt, 32'd0);
    chk("reset_flush_cnt", hz.flush_cnt, 32'd0);
    chk("reset_timeout", hz.mem_timeout, 1'b0);

    // Load-use on rs1, single cycle.
    nxt(); lu_on();
    @(negedge clk); chk("lu_rs1", dut_ctrl, 7'b1100100);
    nxt(); idle();
    @(negedge clk); chk("lu_clears", dut_ctrl, 7'b0);
    chk("lu_stall_cnt", hz.stall_cnt, 32'd1);
    chk("lu_flush_cnt", hz.flush_cnt, 32'd1);

    // rd_E = x0 never stalls.
    nxt(); hz.mem_read_E = 1'b1; hz.rd_E = 5'd0; hz.rs1_D = 5'd0; hz.rs1_used_D = 1'b1;
    @(negedge clk); chk("rd_zero_no_stall", dut_ctrl, 7'b0);
    nxt(); idle();
    @(negedge clk); chk("rd_zero_stall_cnt", hz.stall_cnt, 32'd1);
    chk("rd_zero_flush_cnt", hz.flush_cnt, 32'd1);

    // Load-use via rs2; then a match on an unused source.
    nxt(); hz.mem_read_E = 1'b1; hz.rd_E = 5'd7; hz.rs2_D = 5'd7; hz.rs2_used_D = 1'b1; hz.rs1_D = 5'd3;
    @(negedge clk); chk("lu_rs2", dut_ctrl, 7'b1100100);
    nxt(); idle(); hz.mem_read_E = 1'b1; hz.rd_E = 5'd9; hz.rs1_D = 5'd9; hz.rs2_D = 5'd2; hz.rs2_used_D = 1'b1;
    @(negedge clk); chk("unused_src_no_lu", dut_ctrl, 7'b0);

    // Redirect with fetch miss, then two FWAIT cycles (second with a load-use present).
    nxt(); idle(); hz.redirect_E = 1'b1; hz.imem_ready = 1'b0;
    @(negedge clk); chk("redirect", dut_ctrl, 7'b0010100);
    nxt(); hz.redirect_E = 1'b0;
    @(negedge clk); chk("fwait_1", dut_ctrl, 7'b1010000);
    nxt(); lu_on();
    @(negedge clk); chk("fwait_2_over_lu", dut_ctrl, 7'b1010000);
    nxt(); idle();
    @(negedge clk); chk("fwait_exit", dut_ctrl, 7'b0);
    chk("redir_stall_cnt", hz.stall_cnt, 32'd4);
    chk("redir_flush_cnt", hz.flush_cnt, 32'd5);
    nxt(); lu_on(); hz.imem_ready = 1'b0;
    @(negedge clk); chk("run_lu_over_imiss", dut_ctrl, 7'b1100100);

    // dw + redirect + load-use together: freeze wins, redirect applies on dmem_ready.
    nxt(); idle(); lu_on(); hz.redirect_E = 1'b1; hz.dmem_req_M = 1'b1;
    @(negedge clk); chk("freeze_1", dut_ctrl, 7'b1101011);
    nxt();
    @(negedge clk); chk("freeze_2", dut_ctrl, 7'b1101011);
    nxt(); hz.dmem_ready = 1'b1;
    @(negedge clk); chk("redirect_after_ready", dut_ctrl, 7'b0010100);
    nxt(); idle();
    @(negedge clk); chk("simul_stall_cnt", hz.stall_cnt, 32'd7);
    chk("simul_flush_cnt", hz.flush_cnt, 32'd7);

    // Watchdog: 16 wait edges set the sticky flag.
    nxt(); hz.dmem_req_M = 1'b1;
    for (int i = 0; i < WAIT_TO; i++) begin
      @(negedge clk); chk("wd_not_yet", hz.mem_timeout, 1'b0);
      nxt();
    end
    @(negedge clk); chk("wd_set", hz.mem_timeout, 1'b1);
    hz.dmem_ready = 1'b1;
    nxt();
    @(negedge clk); chk("wd_sticky", hz.mem_timeout, 1'b1);
    chk("wd_stall_cnt", hz.stall_cnt, 32'd23);
    nxt(); idle(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    @(negedge clk); chk("wd_reset_flag", hz.mem_timeout, 1'b0);
    chk("wd_reset_stall_cnt", hz.stall_cnt, 32'd0);
    chk("wd_reset_flush_cnt", hz.flush_cnt, 32'd0);

    // Reset in the middle of a data wait.
    nxt(); hz.dmem_req_M = 1'b1;
    nxt(); nxt(); rst_n = 1'b0;
    @(negedge clk); chk("dwait_reset_forced", dut_ctrl, 7'b0);
    nxt(); rst_n = 1'b1; idle();
    @(negedge clk); chk("dwait_reset_release", dut_ctrl, 7'b0);

    // Reset in FWAIT: afterwards a load-use with imem miss resolves as in RUN.
    nxt(); hz.redirect_E = 1'b1; hz.imem_ready = 1'b0;
    nxt(); hz.redirect_E = 1'b0; rst_n = 1'b0;
    nxt(); rst_n = 1'b1; lu_on();
    @(negedge clk); chk("fwait_reset_release", dut_ctrl, 7'b1100100);

    nxt(); idle();
    nxt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It generates the per-stage stall and flush controls consumed by the F/D, D/E, E/M and M/W pipeline registers. It covers load-use hazards, taken-branch/jump redirects, instruction-memory wait and data-memory wait. It also keeps a data-memory wait watchdog and two performance counters. It sits beside the datapath and takes register indices and control bits from the D, E and M stages.

Parameters:
REG_AW, 5, register-index width
WAIT_TO, 16, dmem wait cycles before mem_timeout asserts (≥2)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
rs1_D  in  REG_AW  source 1 index of instruction in D
rs2_D  in  REG_AW  source 2 index of instruction in D
rs1_used_D  in  1  instruction in D reads rs1
rs2_used_D  in  1  instruction in D reads rs2
rd_E  in  REG_AW  destination index in E
mem_read_E  in  1  instruction in E is a load
redirect_E  in  1  taken branch/jump resolved in E
imem_ready  in  1  instruction memory has valid INST_F this cycle
dmem_req_M  in  1  M stage issues load/store
dmem_ready  in  1  data memory completes this cycle
stall_F  out  1  hold PC
stall_D  out  1  hold F/D register
flush_D  out  1  zero F/D register
stall_E  out  1  hold D/E register
flush_E  out  1  zero D/E register
stall_M  out  1  hold E/M register
flush_W  out  1  zero M/W register
mem_timeout  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  cycles with stall_F=1
flush_cnt  out  CNT_W  cycles with flush_D or flush_E =1

Behaviour:
- rst_n low at a clock edge: state→RUN, wait counter→0, mem_timeout→0, both perf counters→0. While rst_n is low, all stall/flush outputs are forced 0 combinationally.
- Stall/flush outputs are combinational from the current state and inputs (zero latency). The stage registers act on them at the next edge.
- Hazard terms:
  - lu = mem_read_E & rd_E≠0 & ((rs1_used_D & rs1_D==rd_E) | (rs2_used_D & rs2_D==rd_E))
  - dw = dmem_req_M & ~dmem_ready
- Same-cycle priority (highest first):
  1. dw: stall_F, stall_D, stall_E, stall_M = 1; flush_W = 1; other flushes 0. The whole pipe freezes and a bubble enters W.
  2. redirect_E: flush_D = 1, flush_E = 1, no stalls.
  3. lu: stall_F = 1, stall_D = 1, flush_E = 1 (one bubble).
  4. ~imem_ready: stall_F = 1, flush_D = 1 (bubble into D, PC held).
  5. Otherwise all 0.
- FSM states: RUN, DWAIT, FWAIT.
  - RUN→DWAIT when dw.
  - DWAIT→RUN when dmem_ready.
  - RUN→FWAIT when redirect_E & ~imem_ready.
  - FWAIT→RUN when imem_ready.
  - In FWAIT, flush_D = 1 and stall_F = 1 until imem_ready. redirect_E in FWAIT applies rule 2 and stays in FWAIT. dw in FWAIT goes to DWAIT; dw always wins.
- lu lasts one cycle by construction: the load advances to M, so the next cycle is clean unless dw.
- Watchdog:
  - Counter increments each cycle dw=1 and clears when dw=0.
  - When the counter reaches WAIT_TO, mem_timeout sets. It stays set until reset.
  - The counter saturates at WAIT_TO.
- Perf counters:
  - stall_cnt increments each cycle stall_F=1; flush_cnt increments each cycle flush_D|flush_E.
  - Both wrap modulo 2^CNT_W and do not count while rst_n is low.
- rst_n low mid-DWAIT or mid-FWAIT: next state RUN, with no residual stalls after release.
- rd_E=0 never causes a load-use stall.

Decomposition:
- Package pipe_pkg holds:
  - typedef hz_state_t {RUN, DWAIT, FWAIT}
  - typedef stage_ctrl_t, a struct of the seven stall/flush bits
  - constant REG_ZERO = 0
- One sub-module, hz_perf_cnt: a saturating/wrapping counter with enable and clear, instantiated for stall_cnt, flush_cnt and the watchdog (saturating mode).

Test Plan:
- Load-use: mem_read_E=1, rd_E=5, rs1_D=5, rs1_used_D=1 for one cycle → stall_F=stall_D=flush_E=1 that cycle only; stall_cnt=1, flush_cnt=1.
- rd_E=0, rs1_D=0, mem_read_E=1, rs1_used_D=1 → all controls 0; counters unchanged.
- Redirect with fetch miss: redirect_E=1, imem_ready=0 for 3 cycles → cycle 0: flush_D=flush_E=1; cycles 1–2: stall_F=flush_D=1 in FWAIT; RUN once imem_ready=1.
- Simultaneous: dw=1, redirect_E=1, lu=1 → only the freeze set (stall_F/D/E/M=1, flush_W=1); redirect applies the cycle dmem_ready=1.
- Watchdog: dmem_req_M=1, dmem_ready=0 for 16 cycles → mem_timeout=1 after the 16th edge and stays 1 after dmem_ready=1; then rst_n=0 for one edge → mem_timeout=0, counters 0.
- Reset in DWAIT: rst_n=0 at cycle 3 of a wait, then inputs idle → state RUN, all controls 0 the first cycle after release.
